alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer that owns one combinational ALU instance. It performs operations the ALU cannot do in one pass by driving the ALU repeatedly and keeping intermediate values in its own registers:
- shift-left by N and shift-right by N, using the ALU 1-bit shifts;
- unsigned shift-add multiply, using ALU ADD and SHIFTL.
It sits between the pipeline's multi-cycle issue point and the ALU, using a valid/ready request/response handshake.

Parameters:
- data_width, 32: operand, result and ALU width.
- shamt_w, 5: shift-amount width; the amount is taken from req_b[shamt_w-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_op  input  2  00 SHL-N, 01 SHR-N, 10 MUL, 11 PASS.
- req_a  input  data_width  operand A (value to shift, or multiplicand).
- req_b  input  data_width  shift amount (low shamt_w bits) or multiplier.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes the result.
- resp_data  output  data_width  result.
- resp_ovf  output  1  overflow / lost-bit flag.
- busy  output  1  high in any state other than IDLE.
- alu_a  output  data_width  ALU operand A.
- alu_b  output  data_width  ALU operand B.
- alu_ctrl  output  4  ALU opcode: 0001 ADD, 0110 SHIFTL, 0111 SHIFTR, 0000 idle (ALU outputs 0).
- alu_z  input  data_width  ALU result.
- alu_overflow  input  1  ALU carry-out, meaningful on ADD only.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset state: state=IDLE; acc, mcand, mplier, count, ovf all cleared.
- Reset output values: req_ready=1, resp_valid=0, resp_data=0, resp_ovf=0, busy=0, alu_a=0, alu_b=0, alu_ctrl=0000.
- Reset asserted mid-operation aborts the operation. No response is produced and no state is kept.
- States: IDLE, SHIFT, MUL_ADD, MUL_SHL, DONE.
- ALU drive: alu_a, alu_b and alu_ctrl are combinational from state and registers. alu_ctrl=0000 in IDLE and DONE.
- Accept edge E0 is the edge where req_valid && req_ready. On E0, latch the operands and clear ovf, then branch on req_op:
  - SHL/SHR: acc=req_a, count=req_b[shamt_w-1:0]. count==0 goes to DONE; otherwise go to SHIFT.
  - MUL: acc=0, mcand=req_a, mplier=req_b. req_b==0 goes to DONE (result 0); otherwise go to MUL_ADD.
  - PASS: acc=req_a, go to DONE.
- SHIFT, one cycle per bit:
  - Drive alu_a=acc, alu_ctrl=SHIFTL or SHIFTR.
  - acc<=alu_z, count<=count-1.
  - SHL only: ovf<=ovf|acc[MSB].
  - Go to DONE when count==1.
  - Latency: DONE is reached N edges after E0.
- MUL_ADD:
  - If mplier[0]=1: drive alu_a=acc, alu_b=mcand, ADD; acc<=alu_z; ovf<=ovf|alu_overflow.
  - If mplier[0]=0: alu_ctrl=0000 and acc holds.
  - Always go to MUL_SHL.
- MUL_SHL:
  - Drive alu_a=mcand, SHIFTL; mcand<=alu_z; mplier<=mplier>>1.
  - If mcand[MSB]=1 and (mplier>>1)!=0, set ovf.
  - If (mplier>>1)==0 go to DONE, else go to MUL_ADD.
  - Latency: DONE is reached 2k edges after E0, where k is the index of the highest set bit of req_b plus 1.
- DONE:
  - resp_valid=1, resp_data=acc, resp_ovf=ovf. These are held stable while resp_ready=0.
  - resp_valid && resp_ready goes to IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake (one IDLE cycle). There is no overlap.
- Shift amounts are masked to shamt_w bits. For example, with defaults req_b=33 shifts by 1.
- MUL result is the low data_width bits of the unsigned product. ovf=1 whenever the true product does not fit.
- req_* inputs are ignored outside IDLE.
- resp_ready is ignored outside DONE.

Test Plan:
- After reset: outputs at reset values. Then SHL a=0x0000_0001, b=4, resp_ready=1 -> resp_data=0x0000_0010, ovf=0, resp_valid 4 edges after accept, alu_ctrl=0110 for exactly 4 cycles.
- SHL a=0x8000_0001, b=1 -> resp_data=0x0000_0002, ovf=1. SHR a=0x0000_00F0, b=4 -> 0x0000_000F, ovf=0. SHL b=0 -> resp_data=a, resp_valid 0 edges after accept (DONE on the accept edge).
- MUL a=7, b=5 -> resp_data=35, ovf=0, resp_valid 6 edges after accept. MUL a=9, b=0 -> 0, DONE at accept. MUL a=0x0001_0000, b=0x0001_0000 -> resp_data=0, ovf=1.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_data/resp_ovf stable, req_ready=0, and a new req_valid is not accepted. Release -> IDLE next cycle, then the next request is accepted.
- Reset pulse mid-MUL (a=0xFFFF, b=0xFFFF, reset after 3 cycles) -> all outputs return to reset values immediately, no resp_valid. A following SHR a=8, b=3 -> result 1.
- PASS op (11), a=0x1234_5678 -> resp_data=0x1234_5678, ovf=0, ALU never driven (alu_ctrl=0000 throughout).

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer wrapped around an external combinational ALU.
// It builds N-bit shifts and an unsigned shift-add multiply out of repeated single ALU
// passes. Intermediate values are kept in local registers.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready    request handshake; req_ready is high only in IDLE
//   req_op                 00 SHL-N, 01 SHR-N, 10 MUL, 11 PASS
//   req_a, req_b           operand A; shift amount (low shamt_w bits) or multiplier
//   resp_valid/resp_ready  response handshake; resp_valid is high only in DONE
//   resp_data, resp_ovf    result and overflow / lost-bit flag
//   busy                   high in any state other than IDLE
//   alu_a, alu_b, alu_ctrl ALU operands and opcode (0001 ADD, 0110 SHL, 0111 SHR, 0000 idle)
//   alu_z, alu_overflow    ALU result and carry-out (carry-out is meaningful on ADD only)
module alu_seq_ctrl #(
    parameter int unsigned data_width = 32,
    parameter int unsigned shamt_w    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [data_width-1:0] req_a,
    input  logic [data_width-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [data_width-1:0] resp_data,
    output logic                  resp_ovf,
    output logic                  busy,
    output logic [data_width-1:0] alu_a,
    output logic [data_width-1:0] alu_b,
    output logic [3:0]            alu_ctrl,
    input  logic [data_width-1:0] alu_z,
    input  logic                  alu_overflow
);

    localparam logic [3:0] AluIdle = 4'b0000;
    localparam logic [3:0] AluAdd  = 4'b0001;
    localparam logic [3:0] AluShl  = 4'b0110;
    localparam logic [3:0] AluShr  = 4'b0111;

    localparam logic [1:0] OpShl  = 2'b00;
    localparam logic [1:0] OpShr  = 2'b01;
    localparam logic [1:0] OpMul  = 2'b10;
    localparam logic [1:0] OpPass = 2'b11;

    localparam logic [shamt_w-1:0] CountOne = shamt_w'(1);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StMulAdd,
        StMulShl,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [data_width-1:0] acc_q, acc_d;
    logic [data_width-1:0] mcand_q, mcand_d;
    logic [data_width-1:0] mplier_q, mplier_d;
    logic [shamt_w-1:0]    count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  shr_q, shr_d;   // shift direction for the SHIFT state: 1 = right

    logic                  accept;
    logic [data_width-1:0] mplier_next;
    logic [shamt_w-1:0]    req_shamt;

    assign accept      = req_valid && (state_q == StIdle);
    assign mplier_next = mplier_q >> 1;
    assign req_shamt   = req_b[shamt_w-1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (req_op)
                        OpShl, OpShr: state_d = (req_shamt == '0) ? StDone : StShift;
                        OpMul:        state_d = (req_b == '0) ? StDone : StMulAdd;
                        OpPass:       state_d = StDone;
                        default:      state_d = StDone;
                    endcase
                end
            end
            StShift:  if (count_q == CountOne) state_d = StDone;
            StMulAdd: state_d = StMulShl;
            StMulShl: state_d = (mplier_next == '0) ? StDone : StMulAdd;
            StDone:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic: handshake signals and ALU drive
    always_comb begin
        req_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        resp_valid = (state_q == StDone);
        resp_data  = (state_q == StDone) ? acc_q : '0;
        resp_ovf   = (state_q == StDone) ? ovf_q : 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = AluIdle;
        unique case (state_q)
            StShift: begin
                alu_a    = acc_q;
                alu_ctrl = shr_q ? AluShr : AluShl;
            end
            StMulAdd: begin
                // A zero multiplier bit skips the add, so the ALU is left idle.
                if (mplier_q[0]) begin
                    alu_a    = acc_q;
                    alu_b    = mcand_q;
                    alu_ctrl = AluAdd;
                end
            end
            StMulShl: begin
                alu_a    = mcand_q;
                alu_ctrl = AluShl;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        shr_d    = shr_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    ovf_d = 1'b0;
                    unique case (req_op)
                        OpShl, OpShr: begin
                            acc_d   = req_a;
                            count_d = req_shamt;
                            shr_d   = req_op[0];
                        end
                        OpMul: begin
                            acc_d    = '0;
                            mcand_d  = req_a;
                            mplier_d = req_b;
                        end
                        default: acc_d = req_a;
                    endcase
                end
            end
            StShift: begin
                acc_d   = alu_z;
                count_d = count_q - CountOne;
                if (!shr_q) ovf_d = ovf_q | acc_q[data_width-1];
            end
            StMulAdd: begin
                if (mplier_q[0]) begin
                    acc_d = alu_z;
                    ovf_d = ovf_q | alu_overflow;
                end
            end
            StMulShl: begin
                mcand_d  = alu_z;
                mplier_d = mplier_next;
                // The bit shifted out of mcand would still be added by a later multiplier bit.
                if (mcand_q[data_width-1] && (mplier_next != '0)) ovf_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            shr_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            shr_q    <= shr_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl. A behavioural ALU model closes the alu_* loop.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_ovf;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_z;
    logic        alu_overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_ovf     (resp_ovf),
        .busy         (busy),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_z        (alu_z),
        .alu_overflow (alu_overflow)
    );

    // Reference ALU
    always_comb begin
        alu_z        = '0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'b0001: {alu_overflow, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0110: alu_z = alu_a << 1;
            4'b0111: alu_z = alu_a >> 1;
            default: ;
        endcase
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        ovf;
        int          lat;     // edges from accept to resp_valid
        int          active;  // cycles with a non-idle alu_ctrl
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_resp_ovf"}, 32'(resp_ovf), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    endtask

    // Issue one request from IDLE and wait for the response (resp_ready assumed high).
    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] data, output logic ovf,
                           output int lat, output int active);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat       = 0;
        active    = 0;
        while (!resp_valid && lat < 200) begin
            if (alu_ctrl != 4'b0000) active++;
            tick();
            lat++;
        end
        data = resp_data;
        ovf  = resp_ovf;
        tick();
    endtask

    vec_t        vecs[12];
    logic [31:0] r_data;
    logic        r_ovf;
    int          r_lat;
    int          r_act;
    int          seen;

    initial begin
        vecs[0]  = '{"shl4",      2'b00, 32'h0000_0001, 32'd4,  32'h0000_0010, 1'b0, 4,  4};
        vecs[1]  = '{"shl_msb",   2'b00, 32'h8000_0001, 32'd1,  32'h0000_0002, 1'b1, 1,  1};
        vecs[2]  = '{"shr4",      2'b01, 32'h0000_00F0, 32'd4,  32'h0000_000F, 1'b0, 4,  4};
        vecs[3]  = '{"shl0",      2'b00, 32'h0000_ABCD, 32'd0,  32'h0000_ABCD, 1'b0, 0,  0};
        vecs[4]  = '{"shl_mask",  2'b00, 32'h0000_0003, 32'd33, 32'h0000_0006, 1'b0, 1,  1};
        vecs[5]  = '{"shr_lsb",   2'b01, 32'h0000_0001, 32'd1,  32'h0000_0000, 1'b0, 1,  1};
        vecs[6]  = '{"mul7x5",    2'b10, 32'd7,         32'd5,  32'd35,        1'b0, 6,  5};
        vecs[7]  = '{"mul_b0",    2'b10, 32'd9,         32'd0,  32'd0,         1'b0, 0,  0};
        vecs[8]  = '{"mul_big",   2'b10, 32'h0001_0000, 32'h0001_0000, 32'd0,  1'b1, 34, 18};
        vecs[9]  = '{"mul_wrap",  2'b10, 32'hFFFF_FFFF, 32'd2,  32'hFFFF_FFFE, 1'b1, 4,  3};
        vecs[10] = '{"mul_msbok", 2'b10, 32'h8000_0000, 32'd1,  32'h8000_0000, 1'b0, 2,  2};
        vecs[11] = '{"pass",      2'b11, 32'h1234_5678, 32'hFFFF, 32'h1234_5678, 1'b0, 0, 0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        check_reset_outputs("idle");

        foreach (vecs[i]) begin
            run_req(vecs[i].op, vecs[i].a, vecs[i].b, r_data, r_ovf, r_lat, r_act);
            check({vecs[i].name, "_data"}, r_data, vecs[i].data);
            check({vecs[i].name, "_ovf"}, 32'(r_ovf), 32'(vecs[i].ovf));
            check({vecs[i].name, "_lat"}, 32'(r_lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_alu_cycles"}, 32'(r_act), 32'(vecs[i].active));
            check({vecs[i].name, "_back_idle"}, 32'(req_ready), 32'd1);
        end

        // Backpressure: response held while resp_ready is low, new request ignored.
        resp_ready = 1'b0;
        req_op     = 2'b00;
        req_a      = 32'd1;
        req_b      = 32'd2;
        req_valid  = 1'b1;
        tick();
        req_op = 2'b11;
        req_a  = 32'h0000_DEAD;
        seen   = 0;
        while (!resp_valid && seen < 50) begin
            tick();
            seen++;
        end
        check("bp_reach_done", 32'(resp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_data", resp_data, 32'd4);
            check("bp_ovf", 32'(resp_ovf), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        check("bp_release_idle", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        check("bp_next_valid", 32'(resp_valid), 32'd1);
        check("bp_next_data", resp_data, 32'h0000_DEAD);
        tick();
        check("bp_next_idle", 32'(req_ready), 32'd1);

        // Reset pulse in the middle of a multiply.
        req_op    = 2'b10;
        req_a     = 32'h0000_FFFF;
        req_b     = 32'h0000_FFFF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        reset = 1'b0;
        seen  = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid) seen++;
            tick();
        end
        check("midrst_no_resp", 32'(seen), 32'd0);
        run_req(2'b01, 32'd8, 32'd3, r_data, r_ovf, r_lat, r_act);
        check("after_rst_shr_data", r_data, 32'd1);
        check("after_rst_shr_lat", 32'(r_lat), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
